// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - read-side handshake between the byte FIFO and its consumer
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic                 re_en;
    logic                 buf_emp;
    logic [DATA_BITS-1:0] buf_out;

    modport master (output re_en, input buf_emp, input buf_out);
    modport slave  (input re_en, output buf_emp, output buf_out);

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// rtl/fifo_uart_tx_baud_gen.sv - bit-period counter; bit_end marks the last cycle of each bit
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the FIFO read side and sends them as UART frames
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           frame_cnt
);
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_FETCH  = FETCH;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP   = STOP;
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic [2:0]           idx;
    logic                 bit_end;
    logic                 stop_end;
    logic                 pop_ok;

    // Counter restarts in FETCH so the start bit gets a full period.
    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state == S_IDLE) || (state == S_FETCH)),
        .bit_end (bit_end)
    );

    assign stop_end   = (state == S_STOP) && bit_end;
    assign pop_ok     = tx_en && !fifo.buf_emp && !rst;
    assign fifo.re_en = pop_ok && ((state == S_IDLE) || stop_end);
    assign tx_done    = stop_end;
    assign busy       = (state != S_IDLE);

    always_comb begin
        tx = IDLE_LEVEL;
        case (state)
            S_START:  tx = ~IDLE_LEVEL;
            S_DATA:   tx = shreg[0];
            S_PARITY: tx = par;
            default:  tx = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            par       <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo.re_en) state <= S_FETCH;
                end
                S_FETCH: begin
                    shreg <= fifo.buf_out;
                    par   <= even_parity(fifo.buf_out);
                    idx   <= '0;
                    state <= S_START;
                end
                S_START: begin
                    if (bit_end) state <= S_DATA;
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        idx   <= idx + 3'd1;
                        if (idx == LAST_IDX) state <= PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (bit_end) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= fifo.re_en ? S_FETCH : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx, with and without parity
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx_en;
    always #5 clk = ~clk;

    fifo_uart_tx_if ifc0 ();
    fifo_uart_tx_if ifc1 ();

    logic [1:0]       tx_w, busy_w, done_w, re_w, emp_w;
    logic [1:0][15:0] fcnt;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(ifc0.master),
        .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .frame_cnt(fcnt[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(ifc1.master),
        .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .frame_cnt(fcnt[1]));

    // FIFO read-side model: data appears the cycle after a pop
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
    logic [1:0] pop = '0;
    assign ifc0.buf_emp = (wp0 == rp0);
    assign ifc1.buf_emp = (wp1 == rp1);
    assign re_w  = {ifc1.re_en, ifc0.re_en};
    assign emp_w = {ifc1.buf_emp, ifc0.buf_emp};

    int cyc = 0;
    int rcnt [2] = '{0, 0};
    int bad = 0;
    int fc_exp [2] = '{0, 0};
    logic [10:0] fbits [2];
    int fst [2];
    int passed = 0, total = 0;
    logic [7:0] rnd [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pop[k] = (re_w[k] === 1'b1);
            if (pop[k]) begin
                rcnt[k]++;
                if (emp_w[k] || (busy_w[k] && !done_w[k])) bad++;
            end
        end
    end

    always @(posedge clk) begin
        if (pop[0]) begin ifc0.buf_out <= mem0[rp0 % 256]; rp0 <= rp0 + 1; end
        if (pop[1]) begin ifc1.buf_out <= mem1[rp1 % 256]; rp1 <= rp1 + 1; end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem0[wp0 % 256] = b; wp0++;
        mem1[wp1 % 256] = b; wp1++;
    endtask

    // Reference frame: start 0, data LSB first, even parity (if enabled), stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] b, input int pe);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (pe != 0) f[9] = ((ones % 2) == 1);
        return f;
    endfunction

    task automatic frame_check(input int k, input logic [7:0] b);
        int n, nb, dcnt, dat;
        logic [10:0] bits;
        nb = 10 + k; n = 0; dcnt = 0; dat = -1; bits = '1;
        @(negedge clk);
        while (tx_w[k] !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        if (tx_w[k] !== 1'b0) begin
            check($sformatf("start_timeout_i%0d", k), 32'd0, 32'd1);
            fst[k] = -1;
            return;
        end
        fst[k] = cyc;
        for (int c = 0; c < nb * CPB; c++) begin
            if ((c % CPB) == CPB / 2) bits[c / CPB] = tx_w[k];
            if (done_w[k] === 1'b1) begin dcnt++; dat = c; end
            @(negedge clk);
        end
        fbits[k] = bits;
        fc_exp[k] = (fc_exp[k] + 1) % 65536;
        check($sformatf("frame_bits_i%0d_%02h", k, b), 32'(bits), 32'(model_frame(b, k)));
        check($sformatf("tx_done_i%0d", k), 32'(dcnt * 1000 + dat), 32'(1000 + nb * CPB - 1));
        check($sformatf("frame_cnt_i%0d", k), 32'(fcnt[k]), 32'(fc_exp[k]));
    endtask

    task automatic burst_rx(input int k);
        int prev;
        prev = 0;
        for (int i = 0; i < 64; i++) begin
            frame_check(k, 8'(i));
            if (i > 0) check($sformatf("spacing_i%0d", k), 32'(fst[k] - prev), 32'((10 + k) * CPB + 1));
            prev = fst[k];
        end
    endtask

    task automatic rand_rx(input int k);
        for (int i = 0; i < 16; i++) frame_check(k, rnd[i]);
    endtask

    task automatic drop_driver(input logic [15:0] f0);
        int n;
        n = 0;
        while (fcnt[0] == f0 && n < 2000) begin @(negedge clk); n++; end
        while (tx_w[0] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) check("drop_sync_timeout", 32'd0, 32'd1);
        repeat (10) tick();
        tx_en = 1'b0;
    endtask

    task automatic idle_check(input string name);
        for (int k = 0; k < 2; k++)
            check($sformatf("%s_i%0d", name, k), {30'd0, tx_w[k], busy_w[k]}, 32'd2);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int r0, r1, n;
        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h03, 1'b0};
        tbl[3] = '{8'hFF, 1'b0};
        tbl[4] = '{8'h80, 1'b1};
        tbl[5] = '{8'h00, 1'b0};

        // Reset held with a non-empty FIFO
        rst = 1'b1; tx_en = 1'b1;
        push(8'h3C);
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check($sformatf("reset_hold_i%0d", k),
                      {12'd0, tx_w[k], re_w[k], busy_w[k], done_w[k], fcnt[k]}, 32'h80000);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("first_re_en", {30'd0, re_w}, 32'd3);
        @(negedge clk);
        check("fetch_line", {28'd0, tx_w, busy_w}, 32'hF);
        @(negedge clk);
        check("start_edge", {30'd0, tx_w}, 32'd0);
        repeat (60) tick();
        for (int k = 0; k < 2; k++) begin
            fc_exp[k] = 1;
            check($sformatf("first_frame_cnt_i%0d", k), 32'(fcnt[k]), 32'd1);
        end
        idle_check("after_first");

        // Table: single frames, parity bit against hand-computed value
        for (int i = 0; i < 6; i++) begin
            r0 = rcnt[0]; r1 = rcnt[1];
            tick();
            push(tbl[i].data);
            fork
                frame_check(0, tbl[i].data);
                frame_check(1, tbl[i].data);
            join
            check($sformatf("parity_bit_%02h", tbl[i].data), 32'(fbits[1][9]), 32'(tbl[i].par));
            check($sformatf("one_pop_%02h", tbl[i].data), 32'((rcnt[0] - r0) * 16 + rcnt[1] - r1), 32'h11);
            repeat (4) tick();
            idle_check("tbl_idle");
        end

        // Burst of 64 bytes
        r0 = rcnt[0]; r1 = rcnt[1];
        fork
            for (int i = 0; i < 64; i++) begin tick(); push(8'(i)); end
            burst_rx(0);
            burst_rx(1);
        join
        repeat (10) tick();
        check("burst_pops_i0", 32'(rcnt[0] - r0), 32'd64);
        check("burst_pops_i1", 32'(rcnt[1] - r1), 32'd64);
        idle_check("burst_idle");

        // Randomized bytes with random gaps
        for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom_range(0, 255));
        fork
            for (int i = 0; i < 16; i++) begin
                repeat ($urandom_range(0, 50)) tick();
                push(rnd[i]);
            end
            rand_rx(0);
            rand_rx(1);
        join
        repeat (10) tick();
        idle_check("rand_idle");

        // Enable dropped during frame 2
        r0 = rcnt[0]; r1 = rcnt[1];
        tick(); push(8'h11);
        tick(); push(8'h22);
        tick(); push(8'h33);
        fork
            begin frame_check(0, 8'h11); frame_check(0, 8'h22); end
            begin frame_check(1, 8'h11); frame_check(1, 8'h22); end
            drop_driver(fcnt[0]);
        join
        repeat (60) tick();
        check("drop_pops_i0", 32'(rcnt[0] - r0), 32'd2);
        check("drop_pops_i1", 32'(rcnt[1] - r1), 32'd2);
        idle_check("drop_idle");
        tick(); tx_en = 1'b1;
        fork
            frame_check(0, 8'h33);
            frame_check(1, 8'h33);
        join
        repeat (10) tick();

        // Reset during data bit 3
        r0 = rcnt[0]; r1 = rcnt[1];
        tick(); push(8'h44); push(8'h55);
        n = 0;
        @(negedge clk);
        while (tx_w[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("mid_reset_sync", {31'd0, tx_w[0]}, 32'd0);
        repeat (17) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        check("re_en_in_reset", {30'd0, re_w}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            fc_exp[k] = 0;
            check($sformatf("mid_reset_i%0d", k), {14'd0, tx_w[k], busy_w[k], fcnt[k]}, 32'h20000);
        end
        @(posedge clk); #1; rst = 1'b0;
        fork
            frame_check(0, 8'h55);
            frame_check(1, 8'h55);
        join
        repeat (10) tick();
        check("reset_pops", 32'((rcnt[0] - r0) * 16 + rcnt[1] - r1), 32'h22);
        idle_check("final_idle");
        check("illegal_pops", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the dual-clock byte FIFO from its read side. It runs entirely in the FIFO read-clock domain and pops one byte at a time with `re_en`, sampling `buf_out` on the next cycle. Each byte is shifted out as an asynchronous UART frame on `tx`: start bit, 8 data bits LSB first, optional even-parity bit, and a stop bit. This gives the FIFO a real consumer for bring-up and board-level loopback.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range is 2 or more.
- `PARITY_EN`, 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- `clk  in  1`: the FIFO read clock. One clock; all logic is on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `tx_en  in  1`: permits new pops. A frame already in progress always completes.
- `buf_emp  in  1`: FIFO empty flag.
- `buf_out  in  8`: FIFO read data. It is valid in the cycle after `re_en` is high.
- `re_en  out  1`: FIFO pop request, one cycle wide and combinational from state.
- `tx  out  1`: serial line, idle high.
- `busy  out  1`: high in every state except IDLE.
- `tx_done  out  1`: one-cycle pulse in the last cycle of the stop bit.
- `frame_cnt  out  16`: number of frames completed; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, FETCH, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1.
  - `re_en` = `tx_en && !buf_emp`.
  - If `re_en` is high, go to FETCH.
- **FETCH** (1 cycle):
  - `tx`=1.
  - Load the shift register from `buf_out`.
  - Compute parity as the XOR of the loaded byte.
  - Go to START.
- **START:**
  - `tx`=0 for `CLKS_PER_BIT` cycles.
  - Then go to DATA with bit index 0.
- **DATA:**
  - `tx` = shift register bit 0 for `CLKS_PER_BIT` cycles.
  - Then shift right and increment the index.
  - After index 7, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:**
  - `tx` = even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Then go to STOP.
- **STOP:**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - In the last cycle:
    - pulse `tx_done`;
    - increment `frame_cnt`;
    - assert `re_en` if `tx_en && !buf_emp`, and if so go to FETCH, else go to IDLE.
- `re_en` is never asserted outside IDLE and the last STOP cycle. The block pops exactly one byte per frame.
- **Widths:**
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits and counts from 0 to `CLKS_PER_BIT-1`.
  - Bit index is 3 bits.
  - `frame_cnt` uses modulo-2^16 arithmetic.

## Timing
- **Reset values:** `tx`=1, `re_en`=0, `busy`=0, `tx_done`=0, `frame_cnt`=0. State IDLE; baud counter, index and shift register all 0.
- **First-frame latency:**
  - `re_en` is high in cycle t (IDLE with a non-empty FIFO).
  - FETCH is cycle t+1.
  - `tx` falls at t+2.
- **Frame length** from the start-bit edge to the end of stop: (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
- **Back-to-back frames:** start-bit to start-bit spacing is exactly (10 + `PARITY_EN`) × `CLKS_PER_BIT` + 1 cycles, counting the one FETCH cycle of idle line.
- **Empty flag:** `buf_emp` is sampled only in the cycles where `re_en` is evaluated. A FIFO that fills mid-frame is seen at the last STOP cycle.
- **`tx_en` low mid-frame:** the frame finishes and the block returns to IDLE with no pop.
- **Reset mid-frame:** the next edge forces `tx`=1 and state IDLE. The byte already popped is discarded, and `frame_cnt` clears.
- **`rst` and `re_en` conditions in the same cycle:** reset wins. `re_en` is 0 while `rst` is high.

## Structure
- **Package `uart_pkg`:**
  - state enum `tx_state_t`;
  - `DATA_BITS`=8;
  - `IDLE_LEVEL`=1'b1.
- **Sub-module `baud_gen`:** holds the baud counter and emits `bit_end`, high in the last cycle of each bit. `clr` restarts it; it is cleared in FETCH and on `rst`.
- The FSM, shift register, parity and frame counter live in the top module.

## Test plan
- **Reset:** `rst` for 3 cycles with a non-empty FIFO -> `tx`=1, `re_en`=0, `frame_cnt`=0 throughout; the first `re_en` appears in the cycle after `rst` falls.
- **Single byte:** `CLKS_PER_BIT`=4, `PARITY_EN`=0, one byte 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1 (4 cycles each); one `re_en` pulse; `tx_done` once; `frame_cnt`=1.
- **Parity:** `PARITY_EN`=1, bytes 0x07 then 0x03 -> parity bit 1, then 0; frame length 44 cycles each.
- **Burst:** 64 bytes 0x00..0x3F with `tx_en` high -> 64 frames in order; start-to-start spacing 41 cycles; 64 `re_en` pulses; `buf_emp` rises after the last pop; the block returns to IDLE.
- **Enable drop:** `tx_en` low during DATA of frame 2 -> frame 2 completes, no further `re_en`; raising `tx_en` resumes with frame 3.
- **Reset mid-frame:** `rst` in DATA bit 3 -> `tx`=1 on the next edge; `frame_cnt`=0; the next frame carries the next FIFO byte, not the aborted one.
